// File: rtl/castle_commit.sv
// Commit-side consumer: tracks castling rights and sequences the
// king/rook board writes for a committed castle move.
module castle_commit #(
    parameter logic [3:0] INIT_FLAGS = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mv_valid,
    output logic        mv_ready,
    input  logic [15:0] mv_data,
    input  logic        mv_color,
    output logic        wr_en,
    output logic [9:0]  wr_piece,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] COL_A = 3'd0;
    localparam logic [2:0] COL_C = 3'd2;
    localparam logic [2:0] COL_D = 3'd3;
    localparam logic [2:0] COL_E = 3'd4;
    localparam logic [2:0] COL_F = 3'd5;
    localparam logic [2:0] COL_G = 3'd6;
    localparam logic [2:0] COL_H = 3'd7;

    localparam logic [2:0] ROW_ONE   = 3'd0;
    localparam logic [2:0] ROW_EIGHT = 3'd7;

    localparam logic [2:0] EMPTY = 3'd0;
    localparam logic [2:0] ROOK  = 3'd4;
    localparam logic [2:0] KING  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        K_CLR,
        K_SET,
        R_CLR,
        R_SET
    } state_t;

    state_t     state;
    logic [2:0] k_col;
    logic [2:0] k_row;
    logic       k_color;

    logic       is_castle;
    logic [2:0] src_col;
    logic [2:0] src_row;
    logic [2:0] dst_col;
    logic [2:0] dst_row;
    logic [2:0] home_row;
    logic       kingside;
    logic       castle_ok;
    logic [3:0] side_mask;
    logic [3:0] touch_mask;
    logic       ks_q;
    logic [2:0] rook_src;
    logic [2:0] rook_dst;
    logic       unused_bits;

    // Rights lost when a move starts or ends on a king/rook home square.
    function automatic logic [3:0] sq_mask(
        input logic [2:0] col,
        input logic [2:0] row
    );
        logic [3:0] m;
        m = 4'b0000;
        if (row == ROW_ONE) begin
            if (col == COL_E) m = 4'b0011;
            if (col == COL_A) m = 4'b0001;
            if (col == COL_H) m = 4'b0010;
        end
        if (row == ROW_EIGHT) begin
            if (col == COL_E) m = 4'b1100;
            if (col == COL_A) m = 4'b0100;
            if (col == COL_H) m = 4'b1000;
        end
        return m;
    endfunction

    assign is_castle   = mv_data[14];
    assign src_col     = mv_data[11:9];
    assign src_row     = mv_data[8:6];
    assign dst_col     = mv_data[5:3];
    assign dst_row     = mv_data[2:0];
    assign unused_bits = ^{mv_data[15], mv_data[13:12]};

    assign home_row   = mv_color ? ROW_EIGHT : ROW_ONE;
    assign kingside   = (dst_col == COL_G);
    assign side_mask  = mv_color ? 4'b1100 : 4'b0011;
    assign touch_mask = sq_mask(src_col, src_row) | sq_mask(dst_col, dst_row);

    assign castle_ok = (src_col == COL_E) &&
                       (src_row == home_row) &&
                       (dst_row == src_row) &&
                       ((dst_col == COL_C) || (dst_col == COL_G)) &&
                       flags[{mv_color, kingside}];

    assign ks_q     = (k_col == COL_G);
    assign rook_src = ks_q ? COL_H : COL_A;
    assign rook_dst = ks_q ? COL_F : COL_D;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flags    <= INIT_FLAGS;
            mv_ready <= 1'b1;
            wr_en    <= 1'b0;
            wr_piece <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            k_col    <= '0;
            k_row    <= '0;
            k_color  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mv_valid) begin
                        if (!is_castle) begin
                            done  <= 1'b1;
                            flags <= flags & ~touch_mask;
                        end else if (!castle_ok) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state    <= K_CLR;
                            mv_ready <= 1'b0;
                            wr_en    <= 1'b1;
                            wr_piece <= {EMPTY, COL_E, src_row, 1'b0};
                            flags    <= flags & ~side_mask;
                            k_col    <= dst_col;
                            k_row    <= src_row;
                            k_color  <= mv_color;
                        end
                    end
                end
                K_CLR: begin
                    state    <= K_SET;
                    wr_piece <= {KING, k_col, k_row, k_color};
                end
                K_SET: begin
                    state    <= R_CLR;
                    wr_piece <= {EMPTY, rook_src, k_row, 1'b0};
                end
                R_CLR: begin
                    state    <= R_SET;
                    wr_piece <= {ROOK, rook_dst, k_row, k_color};
                end
                R_SET: begin
                    state    <= IDLE;
                    wr_en    <= 1'b0;
                    wr_piece <= '0;
                    done     <= 1'b1;
                    mv_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    wr_en    <= 1'b0;
                    wr_piece <= '0;
                    mv_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
